pipelined_exec_core_p: RTL and testbench
========================================

// Module: pipelined_exec_core_p
// PURPOSE
//  Parametrised successor to the 3-stage execution unit. Fetches 32-bit instructions from an
//  external instruction ROM and decodes them. Reads a 32-entry register file, executes and
//  writes back over three stages: D (fetch/decode/RF read), EX, WB.
//  Adds real operand datapath, RAW hazard handling (forwarding or stall), HALT, run enable, retire counter.
// PARAMETERS
//  DATA_W      32  register/ALU width (8..64)
//  IMEM_AW     8   instruction ROM word-address width; imem_addr = pc[IMEM_AW+1:2]
//  FORWARD_EN  1   1: EX/WB bypass to D, no hazard stalls; 0: stall D on RAW with EX
//  CNT_W       16  width of retire counter
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset rst, synchronous, active-high
//  en           in   1        run enable; 0 freezes all stages (no state change)
//  imem_addr    out  IMEM_AW  ROM word address (comb. from pc)
//  imem_rdata   in   32       ROM data, combinational, same cycle
//  pc           out  32       current fetch byte address
//  stall        out  1        D stage held this cycle (hazard, or halt seen)
//  wb_valid     out  1        instruction retiring this cycle
//  wb_addr      out  5        destination register of retiring instruction
//  wb_data      out  DATA_W   result written this cycle
//  halted       out  1        sticky: HALT retired, pipeline empty
//  illegal      out  1        sticky: undefined opcode decoded
//  retire_cnt   out  CNT_W    count of retired non-NOP, non-HALT instructions, wraps at 2^CNT_W
// BEHAVIOUR
//  Format: opcode[31:25] src2[24:20] src1[19:15] dest[14:10]; other bits ignored.
//  Opcodes: 00 NOP, 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 SLL, 07 SRL, 08 SLT (signed),
//   7F HALT; others = NOP + set illegal.
//  Arithmetic: modulo 2^DATA_W; shift amount = src2 value[$clog2(DATA_W)-1:0]; SLT -> 1/0, zero-extended.
//  r0 reads 0, writes to r0 discarded (wb_valid still asserts, wb_data = computed value).
//  Reset (sync): pc=0, EX/WB valid=0, wb_valid=0, wb_addr=0, wb_data=0.
//   Also halted=0, illegal=0, retire_cnt=0, and RF reg[i]=i for i=1..31.
//   First fetch is from pc=0 in the first cycle after rst deasserts.
//  Latency: instr in D at cycle N -> EX at N+1 -> wb_valid at N+2; RF written at end of N+2.
//  RF read is write-through: D reading the register being written by WB gets the new value.
//  FORWARD_EN=1: D operand = EX result if EX valid & dest match & dest!=0; else RF (write-through).
//   No hazard stalls; dependent back-to-back instructions retire on consecutive cycles.
//  FORWARD_EN=0: stall=1 when EX valid, writes, dest!=0 and dest equals src1 or src2 of D.
//   pc holds, bubble into EX; exactly 1 stall cycle per such hazard.
//  NOP/illegal/HALT flow through as valid but non-writing; wb_valid=0 for them.
//  HALT in D: stop incrementing pc, stall=1 from the next cycle on, insert bubbles.
//   halted=1 two cycles after HALT leaves D; held until rst. Instructions older than HALT complete.
//  en=0: pc, pipeline registers, RF, counters frozen; wb_valid forced 0 while en=0; resumes seamlessly.
//  pc: +4 per non-stalled, enabled cycle; 32-bit wrap; ROM index wraps at 2^IMEM_AW words.
//  rst mid-operation: in-flight instructions discarded, no RF write that cycle.
// TESTING
//  1 Reset then ROM[0]=ADD r3,r1,r2 -> wb_valid cycle 2, wb_addr=3, wb_data=3; retire_cnt=1.
//  2 FORWARD_EN=1: ADD r5,r1,r2; SUB r6,r5,r1 -> wb r5=3 then r6=2 on consecutive cycles, stall never 1.
//  3 FORWARD_EN=0, same program -> stall=1 for exactly one cycle, r6=2 retires one cycle later than in 2.
//  4 SUB r7,r1,r2 (DATA_W=8) -> 8'hFF; SLT r8,r7,r1 -> 1; SLL r9,r1,r31 (shamt 31&7=7) -> 8'h80.
//  5 ADD r0,r1,r2; ADD r4,r0,r0 -> r4=0; opcode 0x55 -> illegal=1, no writeback.
//  6 3 ADDs then HALT; toggle en=0 for 3 cycles mid-run -> results unchanged; halted=1, pc frozen.
//    retire_cnt=3.

Source files
------------

// File: rtl/pipelined_exec_core_p.sv
// rtl/pipelined_exec_core_p.sv - 3-stage (D/EX/WB) execution core with ROM fetch, RF, bypass/stall and HALT
module pipelined_exec_core_p #(
    parameter int DATA_W     = 32,
    parameter int IMEM_AW    = 8,
    parameter int FORWARD_EN = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         pc,
    output logic                stall,
    output logic                wb_valid,
    output logic [4:0]          wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    retire_cnt
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [6:0] OP_NOP  = 7'h00;
    localparam logic [6:0] OP_HALT = 7'h7F;

    logic [31:0]       pc_q, pc_d;
    logic              ex_valid_q, ex_valid_d, ex_writes_q, ex_writes_d, ex_halt_q, ex_halt_d;
    logic [3:0]        ex_op_q, ex_op_d;
    logic [4:0]        ex_dest_q, ex_dest_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              halt_seen_q, halt_seen_d, halted_q, halted_d, illegal_q, illegal_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rf_d [32];

    logic [6:0]        d_op;
    logic [4:0]        d_s1, d_s2, d_dest;
    logic              d_alu, d_halt, d_illegal, hazard;
    logic [DATA_W-1:0] ex_result;
    logic [SH_W-1:0]   shamt;
    logic              unused_bits;

    assign d_op        = imem_rdata[31:25];
    assign d_s2        = imem_rdata[24:20];
    assign d_s1        = imem_rdata[19:15];
    assign d_dest      = imem_rdata[14:10];
    assign unused_bits = ^imem_rdata[9:0];

    assign d_alu     = (d_op >= 7'h01) && (d_op <= 7'h08);
    assign d_halt    = (d_op == OP_HALT);
    assign d_illegal = !d_alu && !d_halt && (d_op != OP_NOP);

    // Without bypass, a D source matching the EX destination waits one cycle for WB write-through.
    assign hazard = (FORWARD_EN == 0) && ex_valid_q && ex_writes_q && (ex_dest_q != 5'd0)
                    && ((ex_dest_q == d_s1) || (ex_dest_q == d_s2));
    assign stall  = halt_seen_q || hazard;

    assign shamt = ex_b_q[SH_W-1:0];

    always_comb begin
        ex_result = '0;
        case (ex_op_q)
            4'd1:    ex_result = ex_a_q + ex_b_q;
            4'd2:    ex_result = ex_a_q - ex_b_q;
            4'd3:    ex_result = ex_a_q & ex_b_q;
            4'd4:    ex_result = ex_a_q | ex_b_q;
            4'd5:    ex_result = ex_a_q ^ ex_b_q;
            4'd6:    ex_result = ex_a_q << shamt;
            4'd7:    ex_result = ex_a_q >> shamt;
            4'd8:    ex_result = {{(DATA_W-1){1'b0}}, ($signed(ex_a_q) < $signed(ex_b_q))};
            default: ex_result = '0;
        endcase
    end

    // Operand priority: r0, then EX bypass, then the value WB is writing this cycle, then the RF.
    function automatic logic [DATA_W-1:0] read_src(input logic [4:0] s);
        if (s == 5'd0) return '0;
        if ((FORWARD_EN != 0) && ex_valid_q && ex_writes_q && (ex_dest_q == s)) return ex_result;
        if (wb_valid_q && (wb_addr_q == s)) return wb_data_q;
        return rf_q[s];
    endfunction

    always_comb begin
        pc_d        = pc_q;
        ex_valid_d  = ex_valid_q;
        ex_writes_d = ex_writes_q;
        ex_halt_d   = ex_halt_q;
        ex_op_d     = ex_op_q;
        ex_dest_d   = ex_dest_q;
        ex_a_d      = ex_a_q;
        ex_b_d      = ex_b_q;
        wb_valid_d  = wb_valid_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        halt_seen_d = halt_seen_q;
        halted_d    = halted_q;
        illegal_d   = illegal_q;
        retire_d    = retire_q;
        rf_d        = rf_q;
        if (en) begin
            pc_d        = (stall || d_halt) ? pc_q : pc_q + 32'd4;
            ex_valid_d  = !stall;
            ex_writes_d = !stall && d_alu;
            ex_halt_d   = !stall && d_halt;
            ex_op_d     = (!stall && d_alu) ? d_op[3:0] : 4'd0;
            ex_dest_d   = d_dest;
            ex_a_d      = read_src(d_s1);
            ex_b_d      = read_src(d_s2);
            halt_seen_d = halt_seen_q || (!stall && d_halt);
            illegal_d   = illegal_q || (!stall && d_illegal);
            wb_valid_d  = ex_valid_q && ex_writes_q;
            wb_addr_d   = ex_dest_q;
            wb_data_d   = ex_result;
            halted_d    = halted_q || (ex_valid_q && ex_halt_q);
            if (wb_valid_q) begin
                retire_d = retire_q + CNT_W'(1);
                if (wb_addr_q != 5'd0) rf_d[wb_addr_q] = wb_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            ex_valid_q  <= 1'b0;
            ex_writes_q <= 1'b0;
            ex_halt_q   <= 1'b0;
            ex_op_q     <= '0;
            ex_dest_q   <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            retire_q    <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= DATA_W'(i);
        end else begin
            pc_q        <= pc_d;
            ex_valid_q  <= ex_valid_d;
            ex_writes_q <= ex_writes_d;
            ex_halt_q   <= ex_halt_d;
            ex_op_q     <= ex_op_d;
            ex_dest_q   <= ex_dest_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            retire_q    <= retire_d;
            rf_q        <= rf_d;
        end
    end

    assign imem_addr  = pc_q[IMEM_AW+1:2];
    assign pc         = pc_q;
    assign wb_valid   = wb_valid_q && en;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;
    assign retire_cnt = retire_q;
endmodule

// File: tb/tb_pipelined_exec_core_p.sv
// tb/tb_pipelined_exec_core_p.sv - scoreboard bench for pipelined_exec_core_p (bypass, stall and 8-bit variants)
module tb_pipelined_exec_core_p;
    logic clk, rst, en;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int n_chk, n_fail;

    logic [31:0] rom_a [256];
    logic [31:0] rom_n [256];
    logic [31:0] rom_w [256];

    logic [7:0]  a_imem_addr, n_imem_addr, w_imem_addr;
    logic [31:0] a_imem_rdata, n_imem_rdata, w_imem_rdata;
    logic [31:0] a_pc, n_pc, w_pc;
    logic        a_stall, n_stall, w_stall, a_wb_valid, n_wb_valid, w_wb_valid;
    logic [4:0]  a_wb_addr, n_wb_addr, w_wb_addr;
    logic [31:0] a_wb_data, n_wb_data;
    logic [7:0]  w_wb_data;
    logic        a_halted, n_halted, w_halted, a_illegal, n_illegal, w_illegal;
    logic [15:0] a_retire_cnt, n_retire_cnt, w_retire_cnt;

    assign a_imem_rdata = rom_a[a_imem_addr];
    assign n_imem_rdata = rom_n[n_imem_addr];
    assign w_imem_rdata = rom_w[w_imem_addr];

    pipelined_exec_core_p u_dut (
        .clk(clk), .rst(rst), .en(en), .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata),
        .pc(a_pc), .stall(a_stall), .wb_valid(a_wb_valid), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
        .halted(a_halted), .illegal(a_illegal), .retire_cnt(a_retire_cnt)
    );
    pipelined_exec_core_p #(.FORWARD_EN(0)) u_nf (
        .clk(clk), .rst(rst), .en(en), .imem_addr(n_imem_addr), .imem_rdata(n_imem_rdata),
        .pc(n_pc), .stall(n_stall), .wb_valid(n_wb_valid), .wb_addr(n_wb_addr), .wb_data(n_wb_data),
        .halted(n_halted), .illegal(n_illegal), .retire_cnt(n_retire_cnt)
    );
    pipelined_exec_core_p #(.DATA_W(8)) u_w8 (
        .clk(clk), .rst(rst), .en(en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .pc(w_pc), .stall(w_stall), .wb_valid(w_wb_valid), .wb_addr(w_wb_addr), .wb_data(w_wb_data),
        .halted(w_halted), .illegal(w_illegal), .retire_cnt(w_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2);
        return {op, s2, s1, d, 10'd0};
    endfunction

    task automatic clear_roms();
        for (int i = 0; i < 256; i++) begin
            rom_a[i] = 32'd0;
            rom_n[i] = 32'd0;
            rom_w[i] = 32'd0;
        end
        sb.delete();
    endtask

    // Reset deasserts just after a rising edge; the next falling edge is cycle 0.
    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1; en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_roms();
        @(posedge clk); #1 rst = 1'b1; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk += 7;
        if (a_pc !== 32'd0)         begin n_fail++; $display("FAIL reset_pc: got %h want 0", a_pc); end
        if (a_wb_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", a_wb_valid); end
        if (a_wb_addr !== 5'd0)     begin n_fail++; $display("FAIL reset_wb_addr: got %0d want 0", a_wb_addr); end
        if (a_wb_data !== 32'd0)    begin n_fail++; $display("FAIL reset_wb_data: got %h want 0", a_wb_data); end
        if (a_halted !== 1'b0)      begin n_fail++; $display("FAIL reset_halted: got %b want 0", a_halted); end
        if (a_illegal !== 1'b0)     begin n_fail++; $display("FAIL reset_illegal: got %b want 0", a_illegal); end
        if (a_retire_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_retire_cnt: got %0d want 0", a_retire_cnt); end
    endtask

    task automatic test_single_add();
        clear_roms();
        rom_a[0] = enc(7'h01, 5'd3, 5'd1, 5'd2);
        sb.push_back('{addr: 5'd3, data: 64'd3, cyc: 2});
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (a_wb_valid === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL single_add_extra: unexpected wb addr=%0d data=%h cyc=%0d", a_wb_addr, a_wb_data, c);
                end else begin
                    e = sb.pop_front();
                    if (a_wb_addr !== e.addr || 64'(a_wb_data) !== e.data || c != e.cyc) begin
                        n_fail++;
                        $display("FAIL single_add_wb: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                                 a_wb_addr, a_wb_data, c, e.addr, e.data, e.cyc);
                    end
                end
            end
        end
        n_chk += 2;
        if (sb.size() != 0) begin n_fail++; $display("FAIL single_add_missing: %0d results never retired", sb.size()); end
        if (a_retire_cnt !== 16'd1) begin n_fail++; $display("FAIL single_add_cnt: got %0d want 1", a_retire_cnt); end
    endtask

    task automatic test_forward();
        int stalls;
        stalls = 0;
        clear_roms();
        rom_a[0] = enc(7'h01, 5'd5, 5'd1, 5'd2);
        rom_a[1] = enc(7'h02, 5'd6, 5'd5, 5'd1);
        sb.push_back('{addr: 5'd5, data: 64'd3, cyc: 2});
        sb.push_back('{addr: 5'd6, data: 64'd2, cyc: 3});
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (a_stall === 1'b1) stalls++;
            if (a_wb_valid === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL forward_extra: unexpected wb addr=%0d data=%h cyc=%0d", a_wb_addr, a_wb_data, c);
                end else begin
                    e = sb.pop_front();
                    if (a_wb_addr !== e.addr || 64'(a_wb_data) !== e.data || c != e.cyc) begin
                        n_fail++;
                        $display("FAIL forward_wb: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                                 a_wb_addr, a_wb_data, c, e.addr, e.data, e.cyc);
                    end
                end
            end
        end
        n_chk += 2;
        if (sb.size() != 0) begin n_fail++; $display("FAIL forward_missing: %0d results never retired", sb.size()); end
        if (stalls != 0) begin n_fail++; $display("FAIL forward_stall: got %0d stall cycles want 0", stalls); end
    endtask

    task automatic test_stall();
        int stalls;
        stalls = 0;
        clear_roms();
        rom_n[0] = enc(7'h01, 5'd5, 5'd1, 5'd2);
        rom_n[1] = enc(7'h02, 5'd6, 5'd5, 5'd1);
        sb.push_back('{addr: 5'd5, data: 64'd3, cyc: 2});
        sb.push_back('{addr: 5'd6, data: 64'd2, cyc: 4});
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (n_stall === 1'b1) stalls++;
            if (n_wb_valid === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL stall_extra: unexpected wb addr=%0d data=%h cyc=%0d", n_wb_addr, n_wb_data, c);
                end else begin
                    e = sb.pop_front();
                    if (n_wb_addr !== e.addr || 64'(n_wb_data) !== e.data || c != e.cyc) begin
                        n_fail++;
                        $display("FAIL stall_wb: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                                 n_wb_addr, n_wb_data, c, e.addr, e.data, e.cyc);
                    end
                end
            end
        end
        n_chk += 2;
        if (sb.size() != 0) begin n_fail++; $display("FAIL stall_missing: %0d results never retired", sb.size()); end
        if (stalls != 1) begin n_fail++; $display("FAIL stall_count: got %0d stall cycles want 1", stalls); end
    endtask

    task automatic test_narrow_alu();
        clear_roms();
        rom_w[0] = enc(7'h02, 5'd7, 5'd1, 5'd2);
        rom_w[1] = enc(7'h08, 5'd8, 5'd7, 5'd1);
        rom_w[2] = enc(7'h06, 5'd9, 5'd1, 5'd31);
        sb.push_back('{addr: 5'd7, data: 64'hFF, cyc: 2});
        sb.push_back('{addr: 5'd8, data: 64'h01, cyc: 3});
        sb.push_back('{addr: 5'd9, data: 64'h80, cyc: 4});
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (w_wb_valid === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL narrow_extra: unexpected wb addr=%0d data=%h cyc=%0d", w_wb_addr, w_wb_data, c);
                end else begin
                    e = sb.pop_front();
                    if (w_wb_addr !== e.addr || 64'(w_wb_data) !== e.data || c != e.cyc) begin
                        n_fail++;
                        $display("FAIL narrow_wb: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                                 w_wb_addr, w_wb_data, c, e.addr, e.data, e.cyc);
                    end
                end
            end
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL narrow_missing: %0d results never retired", sb.size()); end
    endtask

    task automatic test_r0_illegal();
        clear_roms();
        rom_a[0] = enc(7'h01, 5'd0, 5'd1, 5'd2);
        rom_a[1] = enc(7'h01, 5'd4, 5'd0, 5'd0);
        rom_a[2] = enc(7'h55, 5'd12, 5'd1, 5'd2);
        sb.push_back('{addr: 5'd0, data: 64'd3, cyc: 2});
        sb.push_back('{addr: 5'd4, data: 64'd0, cyc: 3});
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (a_wb_valid === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL r0_extra: unexpected wb addr=%0d data=%h cyc=%0d", a_wb_addr, a_wb_data, c);
                end else begin
                    e = sb.pop_front();
                    if (a_wb_addr !== e.addr || 64'(a_wb_data) !== e.data || c != e.cyc) begin
                        n_fail++;
                        $display("FAIL r0_wb: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                                 a_wb_addr, a_wb_data, c, e.addr, e.data, e.cyc);
                    end
                end
            end
        end
        n_chk += 2;
        if (sb.size() != 0) begin n_fail++; $display("FAIL r0_missing: %0d results never retired", sb.size()); end
        if (a_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", a_illegal); end
    endtask

    task automatic test_halt_enable();
        logic [31:0] pc_hold;
        pc_hold = 32'd0;
        clear_roms();
        rom_a[0] = enc(7'h01, 5'd10, 5'd1, 5'd2);
        rom_a[1] = enc(7'h01, 5'd11, 5'd3, 5'd4);
        rom_a[2] = enc(7'h01, 5'd12, 5'd10, 5'd11);
        rom_a[3] = enc(7'h7F, 5'd0, 5'd0, 5'd0);
        sb.push_back('{addr: 5'd10, data: 64'd3, cyc: -1});
        sb.push_back('{addr: 5'd11, data: 64'd7, cyc: -1});
        sb.push_back('{addr: 5'd12, data: 64'd10, cyc: -1});
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                n_chk += 2;
                if (a_wb_valid !== 1'b0) begin n_fail++; $display("FAIL en_wb_gate: got %b want 0 at cyc %0d", a_wb_valid, c); end
                if (a_pc !== pc_hold) begin n_fail++; $display("FAIL en_pc_freeze: got %h want %h at cyc %0d", a_pc, pc_hold, c); end
            end else if (a_wb_valid === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL halt_extra: unexpected wb addr=%0d data=%h cyc=%0d", a_wb_addr, a_wb_data, c);
                end else begin
                    e = sb.pop_front();
                    if (a_wb_addr !== e.addr || 64'(a_wb_data) !== e.data) begin
                        n_fail++;
                        $display("FAIL halt_wb: got addr=%0d data=%h want addr=%0d data=%h",
                                 a_wb_addr, a_wb_data, e.addr, e.data);
                    end
                end
            end
            if (c == 1) begin pc_hold = a_pc; en = 1'b0; end
            if (c == 4) en = 1'b1;
        end
        n_chk += 5;
        if (sb.size() != 0) begin n_fail++; $display("FAIL halt_missing: %0d results never retired", sb.size()); end
        if (a_halted !== 1'b1) begin n_fail++; $display("FAIL halted_flag: got %b want 1", a_halted); end
        if (a_pc !== 32'd12) begin n_fail++; $display("FAIL halt_pc: got %h want 0000000c", a_pc); end
        if (a_stall !== 1'b1) begin n_fail++; $display("FAIL halt_stall: got %b want 1", a_stall); end
        if (a_retire_cnt !== 16'd3) begin n_fail++; $display("FAIL halt_cnt: got %0d want 3", a_retire_cnt); end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        en = 1'b1;
        test_reset();
        test_single_add();
        test_forward();
        test_stall();
        test_narrow_alu();
        test_r0_illegal();
        test_halt_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
